// File: rtl/qft3_measure.sv
// rtl/qft3_measure.sv - basis-state measurement statistics for a 3-qubit QFT amplitude frame
//
// Captures one frame of eight signed complex amplitudes and then walks the basis
// states 0..7, one per cycle. For each state it forms |a|^2 = r*r + i*i at full
// precision. It accumulates the total power and tracks the most probable state.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   frame handshake; in_ready is high only while idle
//   fNNN_r / fNNN_i       signed amplitude of basis state NNN, W bits, F fractional
//   out_valid / out_ready result handshake; results hold until accepted
//   max_idx               index of the largest |a|^2 (lowest index on ties)
//   max_mag               |a|^2 of max_idx, unsigned, 2F fractional bits
//   total_pwr             sum of |a|^2 over all states, unsigned, 2F fractional bits
//   zero_flag             total_pwr == 0

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module qft3_measure #(
  parameter int W = `TOTAL_WIDTH,
  parameter int F = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] f000_r,
  input  logic signed [W-1:0] f000_i,
  input  logic signed [W-1:0] f001_r,
  input  logic signed [W-1:0] f001_i,
  input  logic signed [W-1:0] f010_r,
  input  logic signed [W-1:0] f010_i,
  input  logic signed [W-1:0] f011_r,
  input  logic signed [W-1:0] f011_i,
  input  logic signed [W-1:0] f100_r,
  input  logic signed [W-1:0] f100_i,
  input  logic signed [W-1:0] f101_r,
  input  logic signed [W-1:0] f101_i,
  input  logic signed [W-1:0] f110_r,
  input  logic signed [W-1:0] f110_i,
  input  logic signed [W-1:0] f111_r,
  input  logic signed [W-1:0] f111_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          max_idx,
  output logic [2*W:0]        max_mag,
  output logic [2*W+3:0]      total_pwr,
  output logic                zero_flag
);

  // The fractional position only matters to consumers; it must still fit in W.
  if (F < 0 || F >= W) begin : g_f_range_check
    $error("qft3_measure: F must lie in [0, W-1]");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] in_r [8];
  logic signed [W-1:0] in_i [8];
  logic signed [W-1:0] cap_r_q [8];
  logic signed [W-1:0] cap_i_q [8];

  logic [2:0]      cnt_q;
  logic [2*W:0]    max_mag_q;
  logic [2:0]      max_idx_q;
  logic [2*W+3:0]  acc_q;
  logic [2*W+3:0]  acc_d;
  logic            zero_q;

  logic                  fire_in;
  logic signed [W-1:0]   cur_r;
  logic signed [W-1:0]   cur_i;
  logic signed [2*W-1:0] ext_r;
  logic signed [2*W-1:0] ext_i;
  logic signed [2*W-1:0] sq_r;
  logic signed [2*W-1:0] sq_i;
  logic [2*W:0]          mag;

  assign in_r[0] = f000_r;  assign in_i[0] = f000_i;
  assign in_r[1] = f001_r;  assign in_i[1] = f001_i;
  assign in_r[2] = f010_r;  assign in_i[2] = f010_i;
  assign in_r[3] = f011_r;  assign in_i[3] = f011_i;
  assign in_r[4] = f100_r;  assign in_i[4] = f100_i;
  assign in_r[5] = f101_r;  assign in_i[5] = f101_i;
  assign in_r[6] = f110_r;  assign in_i[6] = f110_i;
  assign in_r[7] = f111_r;  assign in_i[7] = f111_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = SCAN;
      SCAN:    if (cnt_q == 3'd7) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------- datapath
  assign fire_in = in_valid && in_ready;

  assign cur_r = cap_r_q[cnt_q];
  assign cur_i = cap_i_q[cnt_q];

  // Sign-extend before squaring so (-2^(W-1))^2 = 2^(2W-2) is exact.
  assign ext_r = {{W{cur_r[W-1]}}, cur_r};
  assign ext_i = {{W{cur_i[W-1]}}, cur_i};
  assign sq_r  = ext_r * ext_r;
  assign sq_i  = ext_i * ext_i;

  // Both squares are non-negative, so the sum fits in 2W+1 unsigned bits.
  assign mag   = {1'b0, sq_r} + {1'b0, sq_i};
  assign acc_d = acc_q + {3'b000, mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        cap_r_q[k] <= '0;
        cap_i_q[k] <= '0;
      end
      cnt_q     <= '0;
      max_mag_q <= '0;
      max_idx_q <= '0;
      acc_q     <= '0;
      zero_q    <= 1'b0;
    end else if (fire_in) begin
      for (int k = 0; k < 8; k++) begin
        cap_r_q[k] <= in_r[k];
        cap_i_q[k] <= in_i[k];
      end
      cnt_q     <= '0;
      max_mag_q <= '0;
      max_idx_q <= '0;
      acc_q     <= '0;
      zero_q    <= 1'b0;
    end else if (state_q == SCAN) begin
      acc_q <= acc_d;
      // Strict compare keeps the lowest index on ties; index 0 seeds the max.
      if (cnt_q == 3'd0 || mag > max_mag_q) begin
        max_mag_q <= mag;
        max_idx_q <= cnt_q;
      end
      // The flag is settled on the same edge as the final accumulator value.
      if (cnt_q == 3'd7) begin
        zero_q <= (acc_d == '0);
      end
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign max_idx   = max_idx_q;
  assign max_mag   = max_mag_q;
  assign total_pwr = acc_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_qft3_measure.sv
// tb/tb_qft3_measure.sv - directed self-checking bench for qft3_measure

module tb_qft3_measure;

  localparam int W = 6;
  localparam int F = 4;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [2:0]     max_idx;
  logic [2*W:0]   max_mag;
  logic [2*W+3:0] total_pwr;
  logic           zero_flag;
  logic signed [W-1:0] fr [8];
  logic signed [W-1:0] fi [8];

  int total;
  int bad;

  qft3_measure #(.W(W), .F(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .f000_r(fr[0]), .f000_i(fi[0]),
    .f001_r(fr[1]), .f001_i(fi[1]),
    .f010_r(fr[2]), .f010_i(fi[2]),
    .f011_r(fr[3]), .f011_i(fi[3]),
    .f100_r(fr[4]), .f100_i(fi[4]),
    .f101_r(fr[5]), .f101_i(fi[5]),
    .f110_r(fr[6]), .f110_i(fi[6]),
    .f111_r(fr[7]), .f111_i(fi[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .max_idx(max_idx), .max_mag(max_mag),
    .total_pwr(total_pwr), .zero_flag(zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) begin
      fr[k] = '0;
      fi[k] = '0;
    end
  endtask

  // Presents the frame, then scrambles the inputs so late changes would show up.
  // lat counts edges from capture until out_valid is seen (bounded at 20).
  task automatic send_frame(output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fr[k] = W'($urandom);
      fi[k] = W'($urandom);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_frame();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (max_idx !== 3'd0) begin bad++; $display("FAIL reset_max_idx got=%0d want=0", max_idx); end
    total++; if (max_mag !== '0) begin bad++; $display("FAIL reset_max_mag got=%0d want=0", max_mag); end
    total++; if (total_pwr !== '0) begin bad++; $display("FAIL reset_total_pwr got=%0d want=0", total_pwr); end
    total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL reset_zero_flag got=%b want=0", zero_flag); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_uniform();
    int lat;
    clear_frame();
    for (int k = 0; k < 8; k += 4) begin
      fr[k] = 5;  fi[k+1] = -5;  fr[k+2] = -5;  fi[k+3] = 5;
    end
    send_frame(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL uniform_latency got=%0d want=8", lat); end
    total++; if (max_idx !== 3'd0) begin bad++; $display("FAIL uniform_max_idx got=%0d want=0", max_idx); end
    total++; if (max_mag !== 13'd25) begin bad++; $display("FAIL uniform_max_mag got=%0d want=25", max_mag); end
    total++; if (total_pwr !== 16'd200) begin bad++; $display("FAIL uniform_total_pwr got=%0d want=200", total_pwr); end
    total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL uniform_zero_flag got=%b want=0", zero_flag); end
    handshake();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL uniform_release_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uniform_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    int lat;
    clear_frame();
    fr[5] = 16;
    send_frame(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL single_latency got=%0d want=8", lat); end
    total++; if (max_idx !== 3'd5) begin bad++; $display("FAIL single_max_idx got=%0d want=5", max_idx); end
    total++; if (max_mag !== 13'd256) begin bad++; $display("FAIL single_max_mag got=%0d want=256", max_mag); end
    total++; if (total_pwr !== 16'd256) begin bad++; $display("FAIL single_total_pwr got=%0d want=256", total_pwr); end
    handshake();
  endtask

  task automatic test_extremes();
    int lat;
    clear_frame();
    fr[3] = -32;  fi[3] = -32;  fr[6] = 31;
    send_frame(lat);
    total++; if (max_idx !== 3'd3) begin bad++; $display("FAIL extreme_max_idx got=%0d want=3", max_idx); end
    total++; if (max_mag !== 13'd2048) begin bad++; $display("FAIL extreme_max_mag got=%0d want=2048", max_mag); end
    total++; if (total_pwr !== 16'd3009) begin bad++; $display("FAIL extreme_total_pwr got=%0d want=3009", total_pwr); end
    total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL extreme_zero_flag got=%b want=0", zero_flag); end
    handshake();
  endtask

  task automatic test_back_pressure();
    int lat;
    clear_frame();
    fr[3] = -32;  fi[3] = -32;  fr[6] = 31;
    send_frame(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got=%0d want=8", lat); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      clear_frame();
      fr[c] = 30;
      fi[7] = -31;
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d got=%b want=1", c, out_valid); end
      total++; if (max_idx !== 3'd3 || max_mag !== 13'd2048 || total_pwr !== 16'd3009) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%0d/%0d/%0d want=3/2048/3009", c, max_idx, max_mag, total_pwr);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_no_same_cycle_accept got=%b want=0", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_capture got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_midscan();
    int seen;
    int lat;
    clear_frame();
    fr[3] = -32;  fi[3] = -32;  fr[6] = 31;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    total++; if (total_pwr !== '0) begin bad++; $display("FAIL midrst_total_pwr got=%0d want=0", total_pwr); end
    total++; if (max_mag !== '0) begin bad++; $display("FAIL midrst_max_mag got=%0d want=0", max_mag); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", seen); end
    clear_frame();
    send_frame(lat);
    clear_frame();
    total++; if (lat !== 8) begin bad++; $display("FAIL zero_latency got=%0d want=8", lat); end
    total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL zero_flag got=%b want=1", zero_flag); end
    total++; if (max_idx !== 3'd0) begin bad++; $display("FAIL zero_max_idx got=%0d want=0", max_idx); end
    total++; if (max_mag !== '0) begin bad++; $display("FAIL zero_max_mag got=%0d want=0", max_mag); end
    total++; if (total_pwr !== '0) begin bad++; $display("FAIL zero_total_pwr got=%0d want=0", total_pwr); end
    handshake();
  endtask

  task automatic test_tie();
    int lat;
    clear_frame();
    fi[2] = 8;
    fr[6] = 8;
    send_frame(lat);
    total++; if (max_idx !== 3'd2) begin bad++; $display("FAIL tie_max_idx got=%0d want=2", max_idx); end
    total++; if (max_mag !== 13'd64) begin bad++; $display("FAIL tie_max_mag got=%0d want=64", max_mag); end
    total++; if (total_pwr !== 16'd128) begin bad++; $display("FAIL tie_total_pwr got=%0d want=128", total_pwr); end
    handshake();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_uniform();
    test_single();
    test_extremes();
    test_back_pressure();
    test_reset_midscan();
    test_tie();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
